q_digit_sequencer: RTL and testbench
====================================

// Module: q_digit_sequencer
// PURPOSE
//  Upstream control stage of the online divider. Accepts serial quotient digits (MSB first,
//  signed-digit plus/minus encoding) and generates STATE, cnt_master and computation_cycle.
//  Builds the 4-digit sliding q_plus_vec/q_minus_vec window consumed by q_vec_control.
//  Performs on-the-fly conversion of the digits to a two's-complement quotient.
// PARAMETERS
//  N_DIGITS      16  quotient digits per division (2..127)
//  ONLINE_DELAY   4  cycles spent in LOAD before digits are accepted (1..15)
//  WIN            4  window width; fixed at 4 to match the downstream 4-bit vectors
// PORTS
//  clk                input   1  rising-edge clock
//  rst_n              input   1  asynchronous active-low reset
//  start              input   1  one-cycle pulse; honoured only in IDLE
//  q_valid            input   1  digit present this cycle
//  q_p                input   1  digit plus bit  (q_p,q_m): 10=+1, 00=0, 01=-1, 11=illegal
//  q_m                input   1  digit minus bit
//  STATE              output  2  00 IDLE, 01 LOAD, 10 COMPUTE, 11 FLUSH
//  cnt_master         output  9  cycles since start
//  computation_cycle  output  7  digits accepted this division
//  q_plus_vec         output  4  window plus bits; [0] is the newest digit
//  q_minus_vec        output  4  window minus bits
//  q_final            output  N_DIGITS  converted quotient (Q register)
//  done               output  1  one-cycle pulse at end of FLUSH
//  digit_err          output  1  sticky illegal-digit flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async, any state)
//  - STATE=00; cnt_master=0; computation_cycle=0; both vectors=0; Q=0; QM=all ones;
//    done=0; digit_err=0.
//  - Applies immediately, including mid-division; the next division needs a new start.
//  IDLE
//  - start=1 -> LOAD next cycle.
//  - On that transition: clear cnt_master, computation_cycle, vectors and digit_err;
//    Q=0; QM=all ones.
//  - start outside IDLE is ignored.
//  cnt_master
//  - Increments every cycle the state is not IDLE; wraps 511->0; holds in IDLE.
//  LOAD
//  - Lasts exactly ONLINE_DELAY cycles, then COMPUTE. q_valid is ignored.
//  COMPUTE: each cycle with q_valid=1 (digit d)
//  - q_plus_vec  <= {q_plus_vec[2:0], q_p}
//  - q_minus_vec <= {q_minus_vec[2:0], q_m}
//  - Illegal code 11: shifted in as 00 (digit 0).
//  - On-the-fly conversion:
//      d=+1: Q<={Q,1}  QM<={Q,0}
//      d= 0: Q<={Q,0}  QM<={QM,1}
//      d=-1: Q<={QM,1} QM<={QM,0}
//  - computation_cycle increments.
//  - The digit that makes the count N_DIGITS moves the state to FLUSH.
//  - q_valid=0: everything holds except cnt_master.
//  FLUSH
//  - Lasts WIN cycles; each cycle shifts 0 into both vectors.
//  - computation_cycle and Q hold; q_valid is ignored.
//  - On the last FLUSH cycle, done=1 for one cycle, then IDLE.
//  - Vectors read 0000 on entry to IDLE.
//  q_final=Q at all times; stable from the done pulse until the next start.
//  All outputs are registered; a digit appears in the window and in Q one cycle after acceptance.
// CONFIGURATION
//  Q_DIGIT_CHECK_EN
//  - Defined: digit_err is set on any accepted 11 code and stays set until reset or the
//    next start.
//  - Undefined: digit_err is tied to 0; 11 is still treated as digit 0.
// TESTING
//  1. Reset mid-COMPUTE: drop rst_n -> same cycle STATE=00, vectors=0, computation_cycle=0, done=0.
//  2. start in IDLE -> STATE=01 for exactly 4 cycles, then 10; cnt_master=4 on first COMPUTE cycle.
//  3. Digits +1,0,-1,+1 (back-to-back valid)
//     -> q_plus_vec=1001, q_minus_vec=0010, computation_cycle=4, Q[3:0]=0111 (7/16), QM[3:0]=0110.
//  4. Valid gaps: +1, two idle cycles, -1 -> vectors and Q unchanged during gaps;
//     final q_plus_vec=0010, q_minus_vec=0001.
//  5. 16 digits all +1
//     -> after 16th: STATE=11 for 4 cycles, vectors go 1110,1100,1000,0000; done 1 cycle;
//        q_final=16'hFFFF; then STATE=00.
//  6. With Q_DIGIT_CHECK_EN: digit code 11 -> shifted as 0, digit_err=1 held through done,
//     cleared by next start. start pulse during COMPUTE -> no effect.

Source files
------------

// File: rtl/q_digit_sequencer.sv
// Upstream control stage of the online divider: sequences IDLE/LOAD/COMPUTE/FLUSH, builds the
// 4-digit signed-digit window and converts digits on the fly. Optional: Q_DIGIT_CHECK_EN.
module q_digit_sequencer #(
    parameter int N_DIGITS     = 16,
    parameter int ONLINE_DELAY = 4,
    parameter int WIN          = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                q_valid,
    input  logic                q_p,
    input  logic                q_m,
    output logic [1:0]          STATE,
    output logic [8:0]          cnt_master,
    output logic [6:0]          computation_cycle,
    output logic [3:0]          q_plus_vec,
    output logic [3:0]          q_minus_vec,
    output logic [N_DIGITS-1:0] q_final,
    output logic                done,
    output logic                digit_err
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_LOAD    = 2'b01,
        S_COMPUTE = 2'b10,
        S_FLUSH   = 2'b11
    } state_t;

    localparam logic [6:0] LAST_DIGIT = 7'(N_DIGITS - 1);
    localparam logic [3:0] LOAD_LAST  = 4'(ONLINE_DELAY - 1);
    localparam logic [3:0] FLUSH_LAST = 4'(WIN - 1);
    localparam logic [3:0] FLUSH_PRE  = 4'(WIN - 2);

    state_t              state_q;
    logic [3:0]          phase_q;
    logic [8:0]          cnt_q;
    logic [6:0]          cc_q;
    logic [3:0]          plus_q;
    logic [3:0]          minus_q;
    logic [N_DIGITS-1:0] q_q;
    logic [N_DIGITS-1:0] qm_q;
    logic                done_q;

    // Illegal code 11 decodes to neither +1 nor -1, so it behaves as digit 0.
    logic d_pos;
    logic d_neg;
    assign d_pos = q_p & ~q_m;
    assign d_neg = q_m & ~q_p;

`ifdef Q_DIGIT_CHECK_EN
    logic err_q;
    logic d_bad;
    assign d_bad = q_p & q_m;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            phase_q <= 4'd0;
            cnt_q   <= 9'd0;
            cc_q    <= 7'd0;
            plus_q  <= 4'd0;
            minus_q <= 4'd0;
            q_q     <= '0;
            qm_q    <= '1;
            done_q  <= 1'b0;
`ifdef Q_DIGIT_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (state_q != S_IDLE) begin
                cnt_q <= cnt_q + 9'd1;
            end
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_LOAD;
                        phase_q <= 4'd0;
                        cnt_q   <= 9'd0;
                        cc_q    <= 7'd0;
                        plus_q  <= 4'd0;
                        minus_q <= 4'd0;
                        q_q     <= '0;
                        qm_q    <= '1;
`ifdef Q_DIGIT_CHECK_EN
                        err_q   <= 1'b0;
`endif
                    end
                end
                S_LOAD: begin
                    if (phase_q == LOAD_LAST) begin
                        state_q <= S_COMPUTE;
                        phase_q <= 4'd0;
                    end else begin
                        phase_q <= phase_q + 4'd1;
                    end
                end
                S_COMPUTE: begin
                    if (q_valid) begin
                        plus_q  <= {plus_q[2:0], d_pos};
                        minus_q <= {minus_q[2:0], d_neg};
                        cc_q    <= cc_q + 7'd1;
                        // Q holds the quotient so far, QM holds Q minus one ulp.
                        case ({d_pos, d_neg})
                            2'b10: begin
                                q_q  <= {q_q[N_DIGITS-2:0], 1'b1};
                                qm_q <= {q_q[N_DIGITS-2:0], 1'b0};
                            end
                            2'b01: begin
                                q_q  <= {qm_q[N_DIGITS-2:0], 1'b1};
                                qm_q <= {qm_q[N_DIGITS-2:0], 1'b0};
                            end
                            default: begin
                                q_q  <= {q_q[N_DIGITS-2:0], 1'b0};
                                qm_q <= {qm_q[N_DIGITS-2:0], 1'b1};
                            end
                        endcase
`ifdef Q_DIGIT_CHECK_EN
                        if (d_bad) begin
                            err_q <= 1'b1;
                        end
`endif
                        if (cc_q == LAST_DIGIT) begin
                            state_q <= S_FLUSH;
                            phase_q <= 4'd0;
                        end
                    end
                end
                S_FLUSH: begin
                    plus_q  <= {plus_q[2:0], 1'b0};
                    minus_q <= {minus_q[2:0], 1'b0};
                    // Raise done one edge early so it is visible during the last FLUSH cycle.
                    if (phase_q == FLUSH_PRE) begin
                        done_q <= 1'b1;
                    end
                    if (phase_q == FLUSH_LAST) begin
                        state_q <= S_IDLE;
                        phase_q <= 4'd0;
                    end else begin
                        phase_q <= phase_q + 4'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign STATE             = state_q;
    assign cnt_master        = cnt_q;
    assign computation_cycle = cc_q;
    assign q_plus_vec        = plus_q;
    assign q_minus_vec       = minus_q;
    assign q_final           = q_q;
    assign done              = done_q;
`ifdef Q_DIGIT_CHECK_EN
    assign digit_err         = err_q;
`else
    assign digit_err         = 1'b0;
`endif

endmodule

// File: tb/tb_q_digit_sequencer.sv
// Directed testbench for q_digit_sequencer with a value-based quotient model and expected queue.
module tb_q_digit_sequencer;

    localparam int N  = 16;
    localparam int SW = 4 + 4 + 7 + N;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         q_valid;
    logic         q_p;
    logic         q_m;
    logic [1:0]   STATE;
    logic [8:0]   cnt_master;
    logic [6:0]   computation_cycle;
    logic [3:0]   q_plus_vec;
    logic [3:0]   q_minus_vec;
    logic [N-1:0] q_final;
    logic         done;
    logic         digit_err;

    q_digit_sequencer #(.N_DIGITS(N), .ONLINE_DELAY(4), .WIN(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .q_valid(q_valid), .q_p(q_p), .q_m(q_m),
        .STATE(STATE), .cnt_master(cnt_master), .computation_cycle(computation_cycle),
        .q_plus_vec(q_plus_vec), .q_minus_vec(q_minus_vec), .q_final(q_final),
        .done(done), .digit_err(digit_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [SW-1:0] exp_q[$];

    logic [3:0]   m_plus;
    logic [3:0]   m_minus;
    logic [6:0]   m_cc;
    logic [N-1:0] m_q;
    logic         m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic model_clear();
        m_plus  = 4'd0;
        m_minus = 4'd0;
        m_cc    = 7'd0;
        m_q     = '0;
        m_err   = 1'b0;
    endtask

    function automatic logic exp_err();
`ifdef Q_DIGIT_CHECK_EN
        return m_err;
`else
        return 1'b0;
`endif
    endfunction

    task automatic compare_pop(input string tag);
        logic [SW-1:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_queue: observed empty expected entry", tag);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_plus"},  32'(q_plus_vec),        32'(e[SW-1 -: 4]));
            check({tag, "_minus"}, 32'(q_minus_vec),       32'(e[SW-5 -: 4]));
            check({tag, "_cc"},    32'(computation_cycle), 32'(e[N+6 -: 7]));
            check({tag, "_q"},     32'(q_final),           32'(e[N-1:0]));
            check({tag, "_err"},   32'(digit_err),         32'(exp_err()));
        end
    endtask

    // One COMPUTE cycle: the quotient model works on the numeric value Q = 2*Q + d (mod 2^N).
    task automatic cycle(input logic v, input logic [1:0] code);
        int d;
        q_valid = v;
        {q_p, q_m} = code;
        if (v) begin
            d = (code == 2'b10) ? 1 : (code == 2'b01) ? -1 : 0;
            m_plus  = {m_plus[2:0], code == 2'b10};
            m_minus = {m_minus[2:0], code == 2'b01};
            m_q     = (m_q << 1) + N'(d);
            m_cc    = m_cc + 7'd1;
            if (code == 2'b11) m_err = 1'b1;
        end
        exp_q.push_back({m_plus, m_minus, m_cc, m_q});
        tick();
        q_valid = 1'b0;
        compare_pop("digit");
    endtask

    task automatic start_div();
        start = 1'b1;
        tick();
        start = 1'b0;
        model_clear();
        check("load_state0", 32'(STATE), 32'h1);
        check("load_cnt0", 32'(cnt_master), 32'h0);
        check("load_err_clr", 32'(digit_err), 32'h0);
        check("load_plus_clr", 32'(q_plus_vec), 32'h0);
        check("load_q_clr", 32'(q_final), 32'h0);
        q_valid = 1'b1;
        {q_p, q_m} = 2'b10;
        for (int i = 1; i < 4; i++) begin
            tick();
            check("load_state", 32'(STATE), 32'h1);
            check("load_cnt", 32'(cnt_master), 32'(i));
        end
        tick();
        q_valid = 1'b0;
        check("compute_state", 32'(STATE), 32'h2);
        check("compute_cnt", 32'(cnt_master), 32'h4);
        check("compute_cc0", 32'(computation_cycle), 32'h0);
        check("compute_plus0", 32'(q_plus_vec), 32'h0);
    endtask

    task automatic flush_check();
        for (int i = 0; i < 4; i++) begin
            q_valid = 1'b1;
            check("flush_state", 32'(STATE), 32'h3);
            check("flush_done", 32'(done), 32'(i == 3));
            check("flush_plus", 32'(q_plus_vec), 32'(m_plus));
            check("flush_minus", 32'(q_minus_vec), 32'(m_minus));
            check("flush_q", 32'(q_final), 32'(m_q));
            check("flush_err", 32'(digit_err), 32'(exp_err()));
            tick();
            m_plus  = m_plus << 1;
            m_minus = m_minus << 1;
        end
        q_valid = 1'b0;
        check("idle_state", 32'(STATE), 32'h0);
        check("idle_done", 32'(done), 32'h0);
        check("idle_plus", 32'(q_plus_vec), 32'h0);
        check("idle_minus", 32'(q_minus_vec), 32'h0);
        check("idle_cc", 32'(computation_cycle), 32'(N));
        check("idle_q", 32'(q_final), 32'(m_q));
    endtask

    initial begin
        int guard;
        rst_n = 1'b0;
        start = 1'b0;
        q_valid = 1'b0;
        q_p = 1'b0;
        q_m = 1'b0;
        tick();
        tick();
        check("rst_state", 32'(STATE), 32'h0);
        check("rst_cnt", 32'(cnt_master), 32'h0);
        check("rst_cc", 32'(computation_cycle), 32'h0);
        check("rst_vecs", 32'({q_plus_vec, q_minus_vec}), 32'h0);
        check("rst_q", 32'(q_final), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_err", 32'(digit_err), 32'h0);
        rst_n = 1'b1;
        tick();
        check("idle_hold_cnt", 32'(cnt_master), 32'h0);

        // Division 1: +1, 0, -1, +1 back to back.
        start_div();
        cycle(1'b1, 2'b10);
        cycle(1'b1, 2'b00);
        cycle(1'b1, 2'b01);
        cycle(1'b1, 2'b10);
        check("t3_plus", 32'(q_plus_vec), 32'b1001);
        check("t3_minus", 32'(q_minus_vec), 32'b0010);
        check("t3_cc", 32'(computation_cycle), 32'h4);
        check("t3_q", 32'(q_final[3:0]), 32'b0111);

        start = 1'b1;
        cycle(1'b0, 2'b00);
        start = 1'b0;
        check("start_ignored_state", 32'(STATE), 32'h2);
        check("start_ignored_cc", 32'(computation_cycle), 32'h4);

        // Asynchronous reset in the middle of COMPUTE.
        #2 rst_n = 1'b0;
        #1;
        check("arst_state", 32'(STATE), 32'h0);
        check("arst_vecs", 32'({q_plus_vec, q_minus_vec}), 32'h0);
        check("arst_cc", 32'(computation_cycle), 32'h0);
        check("arst_done", 32'(done), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check("arst_stay_idle", 32'(STATE), 32'h0);

        // Division 2: gaps, then a forced illegal digit and random digits to completion.
        start_div();
        cycle(1'b1, 2'b10);
        cycle(1'b0, 2'($urandom_range(0, 3)));
        cycle(1'b0, 2'($urandom_range(0, 3)));
        cycle(1'b1, 2'b01);
        check("t4_plus", 32'(q_plus_vec), 32'b0010);
        check("t4_minus", 32'(q_minus_vec), 32'b0001);
        cycle(1'b1, 2'b11);
        guard = 0;
        while (m_cc < 7'(N) && guard < 200) begin
            cycle($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)));
            guard++;
        end
        check("t4_digits_done", 32'(m_cc), 32'(N));
        flush_check();

        // Division 3: sixteen +1 digits.
        start_div();
        for (int i = 0; i < N; i++) cycle(1'b1, 2'b10);
        check("t5_enter_flush_plus", 32'(q_plus_vec), 32'hF);
        flush_check();
        check("t5_q_all_ones", 32'(q_final), 32'hFFFF);
        check("t5_cnt", 32'(cnt_master), 32'd24);
        tick();
        check("t5_cnt_hold", 32'(cnt_master), 32'd24);
        check("t5_q_hold", 32'(q_final), 32'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
